// File: rtl/arinc_tx_fifo.sv
// rtl/arinc_tx_fifo.sv - buffered ARINC-429 style bipolar RZ word transmitter
module arinc_tx_fifo #(
    parameter int FCLK       = 50000000,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_BITS   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    nvel,
    input  logic                          par_even,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [7:0]                    wr_adr,
    input  logic [22:0]                   wr_dat,
    output logic                          txd1,
    output logic                          txd0,
    output logic                          slp,
    output logic                          busy,
    output logic                          word_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [10:0] NT_1M   = 11'(FCLK / 2000000);
    localparam logic [10:0] NT_100K = 11'(FCLK / 200000);
    localparam logic [10:0] NT_50K  = 11'(FCLK / 100000);
    localparam logic [10:0] NT_12K5 = 11'(FCLK / 25000);

    localparam logic [4:0] GAP_LAST = 5'(2 * GAP_BITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [30:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;

    logic [1:0]    state;
    logic [10:0]   hcnt;
    logic [10:0]   nt;
    logic          half;
    logic [4:0]    bitc;
    logic [4:0]    gcnt;
    logic [30:0]   sr;
    logic          lat_slp;

    logic          full, empty, push, pop, hc_end, gap_end;
    logic [30:0]   head;
    logic [31:0]   seq;
    logic [10:0]   nt_sel;

    assign full     = (cnt == (AW+1)'(FIFO_DEPTH));
    assign empty    = (cnt == '0);
    assign push     = wr_valid && !full;
    assign hc_end   = (hcnt == nt - 11'd1);
    assign gap_end  = (state == S_GAP) && hc_end && (gcnt == GAP_LAST);
    assign pop      = !empty && ((state == S_IDLE) || gap_end);
    assign head     = mem[rptr];

    assign wr_ready  = !full;
    assign fifo_cnt  = cnt;
    assign word_done = gap_end;
    assign busy      = (state != S_IDLE);
    assign slp       = busy ? lat_slp : (nvel == 2'd0);

    // Transmit order, MSB first: label 7..0, data 0..22, parity.
    always_comb begin
        seq = '0;
        seq[31:24] = head[30:23];
        for (int k = 0; k < 23; k++) begin
            seq[23-k] = head[k];
        end
        seq[0] = ~(^head) ^ par_even;
    end

    always_comb begin
        nt_sel = NT_12K5;
        case (nvel)
            2'd3:    nt_sel = NT_1M;
            2'd2:    nt_sel = NT_100K;
            2'd1:    nt_sel = NT_50K;
            default: nt_sel = NT_12K5;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {wr_adr, wr_dat};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            txd1    <= 1'b0;
            txd0    <= 1'b0;
            hcnt    <= '0;
            nt      <= NT_1M;
            half    <= 1'b0;
            bitc    <= '0;
            gcnt    <= '0;
            sr      <= '0;
            lat_slp <= 1'b0;
        end else if (pop) begin
            // First half of label bit 7 goes on the line the cycle after the pop.
            state   <= S_DATA;
            sr      <= seq[30:0];
            txd1    <= seq[31];
            txd0    <= ~seq[31];
            hcnt    <= '0;
            half    <= 1'b0;
            bitc    <= '0;
            nt      <= nt_sel;
            lat_slp <= (nvel == 2'd0);
        end else begin
            case (state)
                S_DATA: begin
                    if (hc_end) begin
                        hcnt <= '0;
                        if (!half) begin
                            half <= 1'b1;
                            txd1 <= 1'b0;
                            txd0 <= 1'b0;
                        end else begin
                            half <= 1'b0;
                            if (bitc == 5'd31) begin
                                state <= S_GAP;
                                gcnt  <= '0;
                            end else begin
                                bitc <= bitc + 5'd1;
                                sr   <= {sr[29:0], 1'b0};
                                txd1 <= sr[30];
                                txd0 <= ~sr[30];
                            end
                        end
                    end else begin
                        hcnt <= hcnt + 11'd1;
                    end
                end
                S_GAP: begin
                    if (hc_end) begin
                        hcnt <= '0;
                        if (gcnt == GAP_LAST) begin
                            state <= S_IDLE;
                        end else begin
                            gcnt <= gcnt + 5'd1;
                        end
                    end else begin
                        hcnt <= hcnt + 11'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arinc_tx_fifo.sv
// tb/tb_arinc_tx_fifo.sv - directed self-checking bench for arinc_tx_fifo
module tb_arinc_tx_fifo;

    // 10 MHz keeps the 12.5 kb/s word short: Nt = 5 / 50 / 100 / 400.
    localparam int TB_FCLK = 10000000;
    localparam int NT3 = 5;
    localparam int NT2 = 50;
    localparam int NT0 = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  nvel;
    logic        par_even;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_adr;
    logic [22:0] wr_dat;
    logic        txd1, txd0, slp, busy, word_done;
    logic [3:0]  fifo_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wd_cnt   = 0;

    arinc_tx_fifo #(.FCLK(TB_FCLK), .FIFO_DEPTH(8), .GAP_BITS(4)) dut (
        .clk(clk), .rst(rst), .nvel(nvel), .par_even(par_even),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_adr(wr_adr), .wr_dat(wr_dat),
        .txd1(txd1), .txd0(txd0), .slp(slp), .busy(busy),
        .word_done(word_done), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (word_done) wd_cnt <= wd_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] make_word(input logic [7:0] a, input logic [22:0] d, input logic pe);
        logic [31:0] w;
        int ones;
        w[31:24] = a;
        for (int k = 0; k < 23; k++) w[23-k] = d[k];
        ones = $countones({a, d});
        w[0] = pe ? (ones % 2 == 1) : (ones % 2 == 0);
        return w;
    endfunction

    task automatic push(input logic [7:0] a, input logic [22:0] d, output int acc, output int wd_seen);
        acc = -1;
        wd_seen = -1;
        wr_adr = a;
        wr_dat = d;
        wr_valid = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (word_done) wd_seen = cyc;
            if (wr_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        check("push_accepted", acc >= 0, 1);
    endtask

    // Checks every cycle of one word plus its gap, starting at the first pulse.
    task automatic rx_word(input int nt, input logic [31:0] exp, input logic exp_slp, output int start);
        logic [31:0] got;
        int shape_err, ctl_err, gap_err, b, ph;
        logic h, e1, e0;
        got = '0;
        shape_err = 0;
        ctl_err = 0;
        gap_err = 0;
        start = -1;
        for (int i = 0; i < 40000 && !(txd1 | txd0); i++) @(negedge clk);
        check("rx_start", txd1 | txd0, 1);
        if (!(txd1 | txd0)) return;
        start = cyc;
        for (int c = 0; c < 64 * nt; c++) begin
            b  = c / (2 * nt);
            ph = c % (2 * nt);
            h  = (ph >= nt);
            e1 = !h && exp[31-b];
            e0 = !h && !exp[31-b];
            if (txd1 !== e1 || txd0 !== e0) shape_err++;
            if (ph == 0) got[31-b] = txd1;
            if (slp !== exp_slp || busy !== 1'b1 || word_done !== 1'b0) ctl_err++;
            @(negedge clk);
        end
        for (int c = 0; c < 8 * nt; c++) begin
            if (txd1 !== 1'b0 || txd0 !== 1'b0 || busy !== 1'b1 || slp !== exp_slp) gap_err++;
            if (word_done !== (c == 8 * nt - 1)) gap_err++;
            @(negedge clk);
        end
        check("word_bits", got, exp);
        check("word_shape", shape_err, 0);
        check("word_ctl", ctl_err, 0);
        check("word_gap", gap_err, 0);
    endtask

    logic [7:0]  t3_adr [3];
    logic [22:0] t3_dat [3];
    int s1, s2, s5a, s5b, acc, wds, wd0, act, target;
    int s3 [3];

    initial begin
        rst = 1'b1;
        nvel = 2'd3;
        par_even = 1'b0;
        wr_valid = 1'b0;
        wr_adr = '0;
        wr_dat = '0;
        t3_adr = '{8'h11, 8'h22, 8'h33};
        t3_dat = '{23'h000F0F, 23'h7FFFFF, 23'h2AAAAA};
        repeat (3) @(negedge clk);
        check("rst_txd1", txd1, 0);
        check("rst_txd0", txd0, 0);
        check("rst_busy", busy, 0);
        check("rst_word_done", word_done, 0);
        check("rst_fifo_cnt", fifo_cnt, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_slp", slp, 0);
        rst = 1'b0;
        nvel = 2'd0;
        @(negedge clk);
        check("slp_idle_live", slp, 1);
        nvel = 2'd3;

        // Label 0xA5, data 1: five ones, odd parity bit is 0.
        push(8'hA5, 23'h000001, acc, wds);
        check("cnt_after_push", fifo_cnt, 1);
        rx_word(NT3, 32'hA580_0000, 1'b0, s1);
        check("word_done_pos", wd_cnt, 1);

        par_even = 1'b1;
        fork
            rx_word(NT3, 32'hA580_0001, 1'b0, s2);
            begin
                push(8'hA5, 23'h000001, acc, wds);
                repeat (3) @(negedge clk);
                par_even = 1'b0;
                nvel = 2'd2;
                for (int k = 0; k < 3; k++) push(t3_adr[k], t3_dat[k], acc, wds);
                check("cnt_three", fifo_cnt, 3);
            end
        join

        wd0 = wd_cnt;
        for (int k = 0; k < 3; k++) begin
            check("cnt_pop", fifo_cnt, 2 - k);
            rx_word(NT2, make_word(t3_adr[k], t3_dat[k], 1'b0), 1'b0, s3[k]);
        end
        check("b2b_first", s3[0] - s2, 72 * NT3);
        check("b2b_second", s3[1] - s3[0], 72 * NT2);
        check("b2b_third", s3[2] - s3[1], 72 * NT2);
        check("word_done_count", wd_cnt - wd0, 3);
        check("idle_busy", busy, 0);
        check("idle_cnt", fifo_cnt, 0);

        nvel = 2'd3;
        fork
            begin
                int st;
                for (int i = 0; i < 10; i++)
                    rx_word(NT3, make_word(8'h40 + 8'(i), 23'h2AAAA5 + 23'(i * 'h10101), 1'b0), 1'b0, st);
            end
            begin
                int a9, w9;
                for (int i = 0; i < 9; i++) push(8'h40 + 8'(i), 23'h2AAAA5 + 23'(i * 'h10101), acc, wds);
                check("full_wr_ready", wr_ready, 0);
                check("full_cnt", fifo_cnt, 8);
                push(8'h49, 23'h2AAAA5 + 23'(9 * 'h10101), a9, w9);
                check("stall_accept", a9 - w9, 1);
            end
        join

        nvel = 2'd0;
        push(8'h3C, 23'h012345, acc, wds);
        fork
            begin
                rx_word(NT0, make_word(8'h3C, 23'h012345, 1'b0), 1'b1, s5a);
                rx_word(NT3, make_word(8'hC3, 23'h054321, 1'b0), 1'b0, s5b);
            end
            begin
                repeat (10) @(negedge clk);
                nvel = 2'd3;
                push(8'hC3, 23'h054321, acc, wds);
            end
        join
        check("slow_word_len", s5b - s5a, 72 * NT0);

        nvel = 2'd2;
        push(8'h5A, 23'h00AAAA, acc, wds);
        target = acc + 2 + 24 * NT2 + 10;
        push(8'h5B, 23'h00BBBB, acc, wds);
        push(8'h5C, 23'h00CCCC, acc, wds);
        for (int i = 0; i < 5000 && cyc < target; i++) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_cnt", fifo_cnt, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_txd1", txd1, 0);
        check("mid_rst_txd0", txd0, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cnt", fifo_cnt, 0);
        check("mid_rst_ready", wr_ready, 1);
        act = 0;
        for (int c = 0; c < 8 * NT2; c++) begin
            if (txd1 || txd0 || busy || word_done) act++;
            @(negedge clk);
        end
        check("post_rst_quiet", act, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arinc_tx_fifo.md
# arinc_tx_fifo

Parametrised ARINC-429-style serial word transmitter. It accepts label/data pairs through a valid/ready write port and buffers them in an internal FIFO. Each word is sent as 32 bipolar return-to-zero bits on `txd1`/`txd0`, followed by a configurable null gap. Words are sent back-to-back while the FIFO holds data. It sits between the host/control logic and the line driver, and replaces the single-word transmitter, which had no buffering, a fixed gap and fixed parity.

## Interface
- `FCLK`, 50000000: clock frequency in Hz.
- `FIFO_DEPTH`, 8: word buffer depth. Must be a power of 2 and ≥ 2.
- `GAP_BITS`, 4: null bit-times after each word. Legal range is 4..15.

- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `nvel`, in, 2: rate select. 3 = 1 Mb/s, 2 = 100 kb/s, 1 = 50 kb/s, 0 = 12.5 kb/s.
- `par_even`, in, 1: 0 selects odd parity (normal). 1 selects even parity (test mode).
- `wr_valid`, in, 1: write request.
- `wr_ready`, out, 1: FIFO not full.
- `wr_adr`, in, 8: label.
- `wr_dat`, in, 23: data field.
- `txd1`, out, 1: line high pulse.
- `txd0`, out, 1: line low pulse.
- `slp`, out, 1: slow-slope select. Equals `nvel==0` of the word on line.
- `busy`, out, 1: word or gap in progress.
- `word_done`, out, 1: one-cycle pulse at the end of each gap.
- `fifo_cnt`, out, clog2(FIFO_DEPTH)+1: number of buffered words.

## Operation
- Half-bit period is Nt = FCLK/(2·rate) clocks:
  - 1 Mb/s: Nt = 25
  - 100 kb/s: Nt = 250
  - 50 kb/s: Nt = 500
  - 12.5 kb/s: Nt = 2000
- The half-bit counter is 11 bits wide, with terminal count Nt.
- Write: a word is accepted on a cycle with `wr_valid & wr_ready`. `wr_ready = !full`, computed from the registered count. A write into a full FIFO is refused even if a pop happens in the same cycle.
- Simultaneous push and pop: `fifo_cnt` is unchanged and pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, DATA, GAP.
- IDLE → DATA when the FIFO is not empty.
  - On that cycle the head word is popped, and `nvel` and `par_even` are latched for the whole word.
  - The bit counter is cleared and the half-bit counter restarts.
- DATA, one bit-time per bit:
  - Bit order: label bits 7..0 (MSB first), then data bits 0..22 (LSB first), then the parity bit.
  - First half-bit: `txd1` is high if the bit is 1, `txd0` is high if the bit is 0.
  - Second half-bit: both outputs are 0.
- Parity bit: with `par_even=0`, the number of ones in all 32 bits is odd. With `par_even=1`, it is even.
- DATA → GAP after bit 31 completes. GAP holds `txd1 = txd0 = 0` for GAP_BITS bit-times.
- GAP end:
  - `word_done` pulses for one cycle.
  - If the FIFO is not empty, the FSM goes straight to DATA with a new pop in the same cycle, so there are no extra idle clocks.
  - Otherwise the FSM goes to IDLE.
- `txd1` and `txd0` are never both high.
- `busy` is 1 in DATA and GAP.
- `slp` follows the latched rate while `busy`, and follows the live `nvel` in IDLE.
- Reset values:
  - `txd1`, `txd0`, `busy`, `word_done`, `fifo_cnt` = 0.
  - `wr_ready` = 1.
  - FSM = IDLE, FIFO empty.
- Reset mid-word: the word is abandoned, line outputs go to 0 on the next cycle, and buffered words are discarded.

## Timing
- Pop on cycle t. The first half-bit of label bit 7 is driven from cycle t+1 for Nt cycles. All line outputs are registered.
- One bit-time is 2·Nt clocks.
- One word is (32+GAP_BITS)·2·Nt clocks. At 1 Mb/s with the defaults this is 36·50 = 1800 clocks.
- `word_done` is asserted on the last clock of the gap. Any following word's first half-bit starts on the next clock.
- `fifo_cnt` updates one cycle after the push or pop edge.
- `wr_ready` falls on the cycle after the write that fills the FIFO.
- Changing `nvel` or `par_even` mid-word has no effect until the next pop.

## Test plan
- Reset, then write adr=0xA5, dat=0x000001, nvel=3, par_even=0. Required response:
  - `txd1` pulses for label bits 1,0,1,0,0,1,0,1 and data bit0.
  - Parity bit = 0 (`txd0` pulse).
  - Each pulse is 25 clocks high, with a 25-clock null after it.
  - `word_done` occurs 1800 clocks after the first pulse.
- Same word with par_even=1: parity bit = 1 (`txd1` pulse). Everything else is identical.
- Write 3 words at nvel=2:
  - They are sent back-to-back, with exactly 4·500 null clocks between words.
  - There are 3 `word_done` pulses.
  - `fifo_cnt` follows 3→2→1→0 at each pop.
- Fill with FIFO_DEPTH+1 writes while transmitting:
  - `wr_ready` is 0 after the 8th accepted word and the 9th write is stalled.
  - The stalled write is accepted on the cycle after the next pop. No word is lost or duplicated.
- Set nvel=0 and change nvel to 3 mid-word:
  - The current word keeps Nt = 2000 and `slp` = 1.
  - The next word uses Nt = 25 and `slp` = 0.
- Assert `rst` for 1 cycle at bit 12 of a word with 2 words queued:
  - On the next cycle `txd1 = txd0 = 0`, `busy` = 0, `fifo_cnt` = 0.
  - No further transmission occurs until a new write.
